mips_muldiv: RTL

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_muldiv.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MIPS HI/LO multiply/divide unit (one bit per cycle).
// Divide support is built only when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MIPS_MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MIPS_MULDIV_DIV_EN
        DIV  = 2'd2,
`endif
        FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Signed ops (MULT, DIV) have op[0] clear; unsigned ops never negate.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    assign a_neg = ~req_op[0] & req_a[WIDTH-1];
    assign b_neg = ~req_op[0] & req_b[WIDTH-1];
    assign abs_a = a_neg ? -req_a : req_a;
    assign abs_b = b_neg ? -req_b : req_b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};
    assign prod_fix = neg_res_q ? -acc_q : acc_q;

`ifdef MIPS_MULDIV_DIV_EN
    logic               neg_rem_q, neg_rem_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    // Restoring step: acc = {remainder, dividend bits becoming quotient bits}.
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dbz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, abs_b};
                            opb_d     = abs_a;
                            neg_res_d = a_neg ^ b_neg;
                            cnt_d     = CNT_LAST;
                            state_d   = MUL;
`ifdef MIPS_MULDIV_DIV_EN
                            is_div_d  = 1'b0;
`endif
                        end
`ifdef MIPS_MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (req_b == '0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, abs_a};
                                opb_d     = abs_b;
                                neg_res_d = a_neg ^ b_neg;
                                neg_rem_d = a_neg;
                                is_div_d  = 1'b1;
                                cnt_d     = CNT_LAST;
                                state_d   = DIV;
                            end
                        end
`endif
                        OP_MTHI: hi_d = req_a;
                        OP_MTLO: lo_d = req_a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_next;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
`ifdef MIPS_MULDIV_DIV_EN
            DIV: begin
                acc_d = div_next;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            FIX: begin
`ifdef MIPS_MULDIV_DIV_EN
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`else
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MIPS_MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign done      = done_q;
`ifdef MIPS_MULDIV_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
